// File: rtl/player_action_encoder_if.sv
// Button/tick inputs and action/pending/cooldown outputs of one player's action encoder.
interface player_action_encoder_if;
  logic [5:0] BTN;
  logic       TICK;
  logic [5:0] ACT;
  logic [5:0] PENDING;
  logic       COOLDOWN;

  modport master (output BTN, TICK, input ACT, PENDING, COOLDOWN);
  modport slave  (input BTN, TICK, output ACT, PENDING, COOLDOWN);
endinterface

// File: rtl/player_action_encoder.sv
// Raw buttons -> synchronized, debounced, edge-queued one-hot action per game tick (J,MR,ML,W,P,K).
// Optional MOVE_REPEAT_EN: held MR/ML keys request a move on every tick.
module player_action_encoder #(
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned JUMP_COOLDOWN = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  player_action_encoder_if.slave bus
);

  localparam int unsigned CW  = $clog2(DEBOUNCE + 1);
  localparam int unsigned CDW = (JUMP_COOLDOWN < 1) ? 1 : $clog2(JUMP_COOLDOWN + 1);
  localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CDW-1:0] CD_LOAD = CDW'(JUMP_COOLDOWN);

  logic [5:0]         sync1, sync2, deb, deb_prev, req;
  logic [5:0]         act_q, pend_q;
  logic               cd_flag_q;
  logic [5:0][CW-1:0] cnt;
  logic [CDW-1:0]     cd;

  logic [5:0]         deb_next, edge_e, req_next, cand, win;
  logic [5:0][CW-1:0] cnt_next;
  logic [CDW-1:0]     cd_next;
  logic               cd_busy;

  always_comb begin
    deb_next = deb;
    cnt_next = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == DB_LAST) deb_next[i] = sync2[i];
        else                   cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_comb begin
    cd_busy  = (cd != '0);
    edge_e   = deb & ~deb_prev;
    if (cd_busy) edge_e[5] = 1'b0;
    req_next = req | edge_e;
    cand     = '0;
    win      = '0;
    cd_next  = cd;
    if (bus.TICK) begin
      // a same-cycle edge is already folded into req_next, so it competes this tick
      cand = req_next;
      if (cd_busy) cand[5] = 1'b0;
`ifdef MOVE_REPEAT_EN
      cand[4:3] = cand[4:3] | deb[4:3];
`endif
      if (cand[4] && cand[3]) begin
        cand[4:3]     = 2'b00;
        req_next[4:3] = 2'b00;
      end
      if      (cand[5]) win[5] = 1'b1;
      else if (cand[0]) win[0] = 1'b1;
      else if (cand[1]) win[1] = 1'b1;
      else if (cand[2]) win[2] = 1'b1;
      else if (cand[4]) win[4] = 1'b1;
      else if (cand[3]) win[3] = 1'b1;
      req_next = req_next & ~win;
      if (win[5])       cd_next = CD_LOAD;
      else if (cd_busy) cd_next = cd - CDW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      deb_prev  <= '0;
      cnt       <= '0;
      req       <= '0;
      cd        <= '0;
      act_q     <= '0;
      pend_q    <= '0;
      cd_flag_q <= 1'b0;
    end else begin
      sync1     <= bus.BTN;
      sync2     <= sync1;
      deb       <= deb_next;
      deb_prev  <= deb;
      cnt       <= cnt_next;
      req       <= req_next;
      cd        <= cd_next;
      act_q     <= win;
      pend_q    <= req_next;
      cd_flag_q <= (cd_next != '0);
    end
  end

  assign bus.ACT      = act_q;
  assign bus.PENDING  = pend_q;
  assign bus.COOLDOWN = cd_flag_q;

endmodule

// File: tb/tb_player_action_encoder.sv
// Scoreboard bench for player_action_encoder: behavioural model predicts ACT/PENDING/COOLDOWN per cycle.
module tb_player_action_encoder;

  localparam int DEB = 4;
  localparam int JCD = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  player_action_encoder_if bus();

  player_action_encoder #(.DEBOUNCE(DEB), .JUMP_COOLDOWN(JCD)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0] act;
    logic [5:0] pend;
    logic       cd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
    end
  endtask

  // Model state: sync stages, synchronized-sample history, debounced level, pending set, cooldown ticks
  bit [5:0]    m_s1, m_s2, m_d, m_dp, m_r;
  int unsigned m_cd;
  bit [5:0]    m_hist[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_d = '0; m_dp = '0; m_r = '0; m_cd = 0;
    m_hist.delete();
  endtask

  task automatic model_step(input bit [5:0] btn, input bit tick);
    bit [5:0]    e, nd, r, c, act;
    int unsigned cd;
    int          w;
    bit          all_diff;
    int          order[6] = '{5, 0, 1, 2, 4, 3};
    e = m_d & ~m_dp;
    if (m_cd != 0) e[5] = 1'b0;
    // debounced level flips once the last DEB synchronized samples all disagree with it
    m_hist.push_back(m_s2);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    nd = m_d;
    if (m_hist.size() == DEB) begin
      for (int i = 0; i < 6; i++) begin
        all_diff = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][i] == m_d[i]) all_diff = 1'b0;
        if (all_diff) nd[i] = ~m_d[i];
      end
    end
    r = m_r | e;
    act = '0;
    cd = m_cd;
    if (tick) begin
      c = r;
      if (m_cd != 0) c[5] = 1'b0;
`ifdef MOVE_REPEAT_EN
      c[4] = c[4] | m_d[4];
      c[3] = c[3] | m_d[3];
`endif
      if (c[4] && c[3]) begin
        c[4] = 1'b0; c[3] = 1'b0; r[4] = 1'b0; r[3] = 1'b0;
      end
      w = -1;
      foreach (order[k]) if (w < 0 && c[order[k]]) w = order[k];
      if (w >= 0) begin
        act[w] = 1'b1;
        r[w]   = 1'b0;
      end
      if (w == 5)      cd = JCD;
      else if (cd > 0) cd = cd - 1;
    end
    m_s2 = m_s1; m_s1 = btn; m_dp = m_d; m_d = nd; m_r = r; m_cd = cd;
    exp_q.push_back(exp_t'{act: act, pend: r, cd: (cd != 0)});
  endtask

  task automatic drive(input logic [5:0] btn, input logic tick);
    bus.BTN  = btn;
    bus.TICK = tick;
    model_step(btn, tick);
  endtask

  task automatic step(input logic [5:0] btn, input logic tick);
    @(negedge CLK);
    drive(btn, tick);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ACT"}, bus.ACT, '0);
    chk({tag, " PENDING"}, bus.PENDING, '0);
    chk({tag, " COOLDOWN"}, {5'b0, bus.COOLDOWN}, '0);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST = 1'b1;
    drive('0, 1'b0);
  endtask

  // Monitor: one expected entry per clock edge once stimulus is running
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ACT", bus.ACT, e.act);
        chk("PENDING", bus.PENDING, e.pend);
        chk("COOLDOWN", {5'b0, bus.COOLDOWN}, {5'b0, e.cd});
      end
    end
  end

  initial begin
    logic [5:0] cur;
    int         hold;
    bus.BTN  = '0;
    bus.TICK = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    check_zero("reset");
    release_reset();

    // basic press: K... here P (bit1) held 10 cycles, tick at cycle 12
    repeat (10) step(6'b000010, 1'b0);
    step('0, 1'b0);
    step('0, 1'b1);
    idle(4);

    // glitch shorter than the debounce window
    repeat (3) step(6'b000001, 1'b0);
    idle(6);
    step('0, 1'b1);
    idle(3);

    // backlog of K, P, W drained one per tick in priority order
    repeat (8) step(6'b000111, 1'b0);
    idle(4);
    repeat (3) step('0, 1'b1);
    idle(3);

    // jump, re-press during cooldown (discarded), then a press after cooldown expires
    repeat (8) step(6'b100000, 1'b0);
    idle(2);
    step('0, 1'b1);
    idle(8);
    repeat (8) step(6'b100000, 1'b0);
    idle(8);
    repeat (3) begin
      step('0, 1'b1);
      idle(3);
    end
    repeat (8) step(6'b100000, 1'b0);
    idle(3);
    step('0, 1'b1);
    idle(8);

    // MR+ML together cancel; then MR held across three ticks
    repeat (8) step(6'b011000, 1'b0);
    idle(8);
    step('0, 1'b1);
    idle(3);
    repeat (8) step(6'b010000, 1'b0);
    repeat (3) begin
      step(6'b010000, 1'b1);
      step(6'b010000, 1'b0);
    end
    idle(8);
    step('0, 1'b1);
    idle(3);

    // asynchronous reset with K and P pending
    repeat (8) step(6'b000011, 1'b0);
    idle(4);
    @(negedge CLK);
    RST      = 1'b0;
    bus.TICK = 1'b0;
    #1;
    check_zero("async reset");
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    check_zero("held reset");
    release_reset();
    idle(10);
    step('0, 1'b1);
    idle(3);

    // randomized press/hold/glitch patterns with random ticks
    cur  = '0;
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 2) == 0) cur = 6'($urandom);
        else                           cur[$urandom_range(0, 5)] = ~cur[$urandom_range(0, 5)];
        hold = $urandom_range(1, 14);
      end
      hold--;
      step(cur, ($urandom_range(0, 3) == 0));
    end
    idle(12);
    repeat (6) step('0, 1'b1);
    idle(4);

    @(posedge CLK);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_action_encoder.md
# player_action_encoder

Front-end stage for each player FSM: converts six raw, asynchronous button levels into the one-hot 6-bit action vector (J,MR,ML,W,P,K = bits 5..0) that the player FSM consumes. It synchronizes, debounces, edge-detects and queues presses, then issues at most one action per game tick in priority order, with a jump cooldown. One instance per player; ACT drives the player's own FSM action input and the opponent FSM's opponent-action input.

## Interface
- DEBOUNCE, 4: cycles a synchronized button must be stable before its debounced level changes (≥1).
- JUMP_COOLDOWN, 3: ticks after an issued J during which new J presses are discarded (0 = no cooldown).
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- BTN  in  6  raw button levels, bit order J,MR,ML,W,P,K (5..0); asynchronous to CLK.
- TICK  in  1  one-cycle game-step strobe, synchronous to CLK.
- ACT  out  6  registered action vector; one-hot or all-zero.
- PENDING  out  6  registered pending-request flags, same bit order.
- COOLDOWN  out  1  high while the jump cooldown counter is non-zero.

## Operation
- Sync: per bit, 2-flop synchronizer; S[i] = second flop.
- Debounce: per bit, counter of width $clog2(DEBOUNCE+1). If S[i] == D[i], counter clears. Otherwise counter increments; when it reaches DEBOUNCE, D[i] <= S[i] and counter clears.
- Edge: E[i] = D[i] & ~D_prev[i], one cycle.
- Pending: R[i] set on E[i]; cleared when bit i is issued. Already-set R[i] plus a new edge stays 1 (no counting). An E[5] arriving while cooldown is non-zero is discarded, not stored.
- Candidates on a TICK cycle: C = R | E (same-cycle edge counts); C[5] masked while cooldown non-zero.
- MR/ML conflict: if C[4] and C[3] are both set, both R[4] and R[3] clear and neither is eligible this tick.
- Priority: J > K > P > W > MR > ML. Winner bit w: ACT <= (1<<w), R[w] cleared; the others stay pending. No candidate: ACT <= 0.
- ACT is 0 on every cycle not directly following a TICK.
- Cooldown: issuing J loads the counter with JUMP_COOLDOWN. Each later TICK decrements it while non-zero. The load takes precedence over a decrement in the same cycle.
- Reset (asynchronous, any time): synchronizers, D, D_prev, debounce counters, R, ACT, PENDING and cooldown all go to 0. An action in flight is lost.

## Timing
- Reset values: ACT = 0, PENDING = 0, COOLDOWN = 0.
- BTN edge to D change: 2 sync cycles + DEBOUNCE cycles. The default is 6 cycles after the first CLK edge that samples the new level.
- Press to ACT: ACT asserts the cycle after the first TICK at or after the E cycle, and is held exactly 1 cycle.
- PENDING reflects R, registered. It updates the cycle after a set or clear.
- Back-to-back TICKs: one action issued per TICK, so a backlog drains in priority order.
- A glitch shorter than DEBOUNCE cycles has no effect.

## Configuration
- MOVE_REPEAT_EN defined:
  - MR/ML are level-driven.
  - On each TICK, C[4] |= D[4] and C[3] |= D[3], so a held move key issues a move on every tick that no higher-priority action wins.
  - The conflict rule still applies.
- MOVE_REPEAT_EN undefined: MR/ML are edge-queued like every other bit (one move per press).

## Test plan
- Reset: RST=0 mid-stream with R=6'b000011 → ACT=0, PENDING=0, COOLDOWN=0 immediately and after release.
- Basic press: BTN=6'b000010 held 10 cycles, TICK at cycle 12 → ACT=6'b000010 for 1 cycle at cycle 13; PENDING[1] 1 then 0.
- Glitch: BTN[0] high for 3 cycles (DEBOUNCE=4) then TICK → ACT stays 0, PENDING stays 0.
- Priority/backlog: press K, P and W before one TICK, then 3 TICKs → ACT = 000001, 000010, 000100 on the successive ticks.
- Jump cooldown (JUMP_COOLDOWN=3):
  - J issued at tick 0; J pressed again before tick 1 → no J on ticks 1–3, PENDING[5]=0, COOLDOWN high through the tick-3 decrement.
  - A J press after that → issued on the next tick.
- MR+ML conflict: both pressed before a TICK → ACT=0, PENDING[4:3]=0. With MOVE_REPEAT_EN, MR held alone over 3 TICKs → ACT=010000 three times.
